physic_block_control_param: RTL and testbench

//  Parametrised SD CMD-line physical-block controller, successor to the fixed 48-bit controller.

---
 rtl/physic_block_control_param.sv | 231 +++++++++++++++++++++++
 tb/tb_physic_block_control_param.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/physic_block_control_param.sv
// SD CMD-line physical-block controller: load/send, response wait with timeout, short/long capture.
// Optional build macro CMD_RETRY_EN re-sends the latched command up to MAX_RETRIES times on timeout.
module physic_block_control_param #(
   parameter int unsigned CMD_WIDTH      = 48,
   parameter int unsigned RESP_WIDTH     = 136,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic                  iClock_SD,
   input  logic                  iReset,
   input  logic                  iStrobe_in,
   input  logic [CMD_WIDTH-1:0]  iCommand_from_CC,
   input  logic                  iNo_response,
   input  logic                  iLong_response,
   input  logic                  iTransmission_complete,
   input  logic                  iReception_complete,
   input  logic [RESP_WIDTH-1:0] iPad_response,
   input  logic                  iAck_in,
   input  logic                  iIdle_in,
   output logic [CMD_WIDTH-1:0]  oCommand_to_PTS,
   output logic                  oReset_wrapper,
   output logic                  oEnable_PTS_wrapper,
   output logic                  oEnable_STP_wrapper,
   output logic                  oPad_enable,
   output logic                  oPad_stable,
   output logic                  oLoad_send,
   output logic                  oStrobe_out,
   output logic                  oCommand_timeout,
   output logic [RESP_WIDTH-1:0] oResponse,
   output logic                  oAck_out
);

   localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = TIMER_WIDTH'(TIMEOUT_CYCLES);

   if (RESP_WIDTH < CMD_WIDTH || TIMEOUT_CYCLES < 2 || MAX_RETRIES > 255) begin : g_param_check
      $error("physic_block_control_param: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      StReset,
      StIdle,
      StLoad,
      StSend,
      StWait,
      StDone,
      StAck
   } state_t;

   state_t                  state_q, state_d;
   logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
   logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
   logic                    no_resp_q, no_resp_d;
   logic                    long_resp_q, long_resp_d;
   logic                    timeout_q, timeout_d;
   logic [RESP_WIDTH-1:0]   response_q, response_d;
   logic                    wrapper_rst_q, wrapper_rst_d;
   logic                    pts_en_q, pts_en_d;
   logic                    stp_en_q, stp_en_d;
   logic                    pad_en_q, pad_en_d;
   logic                    pad_stable_q, pad_stable_d;
   logic                    load_q, load_d;
   logic                    strobe_q, strobe_d;
   logic                    ack_q, ack_d;

`ifdef CMD_RETRY_EN
   localparam int unsigned RETRY_WIDTH = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRIES);

   logic [RETRY_WIDTH-1:0]  retry_q, retry_d;

   always_ff @(posedge iClock_SD or posedge iReset) begin
      if (iReset) begin
         retry_q <= '0;
      end else begin
         retry_q <= retry_d;
      end
   end
`endif

   always_ff @(posedge iClock_SD or posedge iReset) begin
      if (iReset) begin
         state_q       <= StReset;
         timer_q       <= '0;
         cmd_q         <= '0;
         no_resp_q     <= 1'b0;
         long_resp_q   <= 1'b0;
         timeout_q     <= 1'b0;
         response_q    <= '0;
         wrapper_rst_q <= 1'b0;
         pts_en_q      <= 1'b0;
         stp_en_q      <= 1'b0;
         pad_en_q      <= 1'b0;
         pad_stable_q  <= 1'b0;
         load_q        <= 1'b0;
         strobe_q      <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         cmd_q         <= cmd_d;
         no_resp_q     <= no_resp_d;
         long_resp_q   <= long_resp_d;
         timeout_q     <= timeout_d;
         response_q    <= response_d;
         wrapper_rst_q <= wrapper_rst_d;
         pts_en_q      <= pts_en_d;
         stp_en_q      <= stp_en_d;
         pad_en_q      <= pad_en_d;
         pad_stable_q  <= pad_stable_d;
         load_q        <= load_d;
         strobe_q      <= strobe_d;
         ack_q         <= ack_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      cmd_d         = cmd_q;
      no_resp_d     = no_resp_q;
      long_resp_d   = long_resp_q;
      timeout_d     = timeout_q;
      response_d    = response_q;
      wrapper_rst_d = 1'b0;
`ifdef CMD_RETRY_EN
      retry_d       = retry_q;
`endif

      // Abort has priority over every state except the post-reset one.
      if (iIdle_in && state_q != StReset) begin
         state_d       = StIdle;
         wrapper_rst_d = 1'b1;
      end else begin
         unique case (state_q)
            StReset: begin
               state_d       = StIdle;
               wrapper_rst_d = 1'b1;
            end
            StIdle: begin
               if (iStrobe_in && !iAck_in) begin
                  cmd_d       = iCommand_from_CC;
                  no_resp_d   = iNo_response;
                  long_resp_d = iLong_response;
                  timeout_d   = 1'b0;
`ifdef CMD_RETRY_EN
                  retry_d     = '0;
`endif
                  state_d     = StLoad;
               end
            end
            StLoad: begin
               state_d = StSend;
            end
            StSend: begin
               if (iTransmission_complete) begin
                  if (no_resp_q) begin
                     state_d = StDone;
                  end else begin
                     timer_d = '0;
                     state_d = StWait;
                  end
               end
            end
            StWait: begin
               if (timer_q != TIMER_MAX) begin
                  timer_d = timer_q + TIMER_WIDTH'(1);
               end
               // Reception is tested first so it beats a simultaneous expiry.
               if (iReception_complete) begin
                  if (long_resp_q) begin
                     response_d = iPad_response;
                  end else begin
                     response_d = {{(RESP_WIDTH - CMD_WIDTH){1'b0}}, iPad_response[CMD_WIDTH-1:0]};
                  end
                  state_d = StDone;
               end else if (timer_q == TIMER_LAST) begin
`ifdef CMD_RETRY_EN
                  if (retry_q < RETRY_LIMIT) begin
                     retry_d       = retry_q + RETRY_WIDTH'(1);
                     wrapper_rst_d = 1'b1;
                     state_d       = StLoad;
                  end else begin
                     timeout_d = 1'b1;
                     state_d   = StDone;
                  end
`else
                  timeout_d = 1'b1;
                  state_d   = StDone;
`endif
               end
            end
            StDone: begin
               if (iAck_in) begin
                  state_d = StAck;
               end
            end
            StAck: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      // Outputs are registered, decoded from the state being entered.
      load_d        = (state_d == StLoad);
      pad_en_d      = (state_d == StLoad) || (state_d == StSend);
      pts_en_d      = (state_d == StLoad) || (state_d == StSend);
      pad_stable_d  = (state_d == StWait);
      stp_en_d      = (state_d == StWait);
      strobe_d      = (state_d == StDone);
      ack_d         = (state_d == StAck);
      wrapper_rst_d = wrapper_rst_d || ack_d;
   end

   assign oCommand_to_PTS     = cmd_q;
   assign oReset_wrapper      = wrapper_rst_q;
   assign oEnable_PTS_wrapper = pts_en_q;
   assign oEnable_STP_wrapper = stp_en_q;
   assign oPad_enable         = pad_en_q;
   assign oPad_stable         = pad_stable_q;
   assign oLoad_send          = load_q;
   assign oStrobe_out         = strobe_q;
   assign oCommand_timeout    = timeout_q;
   assign oResponse           = response_q;
   assign oAck_out            = ack_q;

endmodule

// File: tb/tb_physic_block_control_param.sv
// Scoreboard bench for physic_block_control_param: driver pushes expected results, monitor
// compares them at each rising oStrobe_out.
module tb_physic_block_control_param;

   localparam int CW = 48;
   localparam int RW = 136;
   localparam int TO = 64;
   localparam int MR = 2;
`ifdef CMD_RETRY_EN
   localparam int NATT = MR + 1;
`else
   localparam int NATT = 1;
`endif

   logic          clk;
   logic          rst;
   logic          strobe_in;
   logic [CW-1:0] cmd_in;
   logic          no_resp_in;
   logic          long_resp_in;
   logic          tx_done;
   logic          rx_done;
   logic [RW-1:0] pad_resp;
   logic          ack_in;
   logic          idle_in;
   logic [CW-1:0] cmd_to_pts;
   logic          reset_wrapper;
   logic          en_pts;
   logic          en_stp;
   logic          pad_enable;
   logic          pad_stable;
   logic          load_send;
   logic          strobe_out;
   logic          cmd_timeout;
   logic [RW-1:0] response;
   logic          ack_out;

   physic_block_control_param #(
      .CMD_WIDTH     (CW),
      .RESP_WIDTH    (RW),
      .TIMEOUT_CYCLES(TO),
      .MAX_RETRIES   (MR)
   ) dut (
      .iClock_SD             (clk),
      .iReset                (rst),
      .iStrobe_in            (strobe_in),
      .iCommand_from_CC      (cmd_in),
      .iNo_response          (no_resp_in),
      .iLong_response        (long_resp_in),
      .iTransmission_complete(tx_done),
      .iReception_complete   (rx_done),
      .iPad_response         (pad_resp),
      .iAck_in               (ack_in),
      .iIdle_in              (idle_in),
      .oCommand_to_PTS       (cmd_to_pts),
      .oReset_wrapper        (reset_wrapper),
      .oEnable_PTS_wrapper   (en_pts),
      .oEnable_STP_wrapper   (en_stp),
      .oPad_enable           (pad_enable),
      .oPad_stable           (pad_stable),
      .oLoad_send            (load_send),
      .oStrobe_out           (strobe_out),
      .oCommand_timeout      (cmd_timeout),
      .oResponse             (response),
      .oAck_out              (ack_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] resp;
      logic          to;
   } exp_t;

   exp_t          exp_q[$];
   logic [RW-1:0] model_resp;
   int            checks;
   int            errors;
   int            load_cnt;

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic check_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: compares each result presented to CC against the oldest expectation.
   initial begin
      logic strobe_prev;
      exp_t e;
      strobe_prev = 1'b0;
      load_cnt    = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            strobe_prev = 1'b0;
         end else begin
            if (load_send) load_cnt++;
            if (strobe_out && !strobe_prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe actual=1 required=0");
               end else begin
                  e = exp_q.pop_front();
                  check_vec("response", response, e.resp);
                  check_bit("timeout_flag", cmd_timeout, e.to);
               end
            end
            strobe_prev = strobe_out;
         end
      end
   end

   function automatic logic [RW-1:0] rand_wide();
      logic [159:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[RW-1:0];
   endfunction

   // kind: 0 no response, 1 short, 2 long, 3 timeout (no reception).
   task automatic do_txn(input int kind, input logic [CW-1:0] cmd, input logic [RW-1:0] pad,
                         input int tx_delay, input int rx_delay);
      exp_t e;
      int   base;
      int   atts;
      bit   got;
      if (kind == 1) model_resp = {{(RW - CW){1'b0}}, pad[CW-1:0]};
      else if (kind == 2) model_resp = pad;
      e.resp = model_resp;
      e.to   = (kind == 3);
      exp_q.push_back(e);
      atts = (kind == 3) ? NATT : 1;
      base = load_cnt;

      cmd_in       = cmd;
      no_resp_in   = (kind == 0);
      long_resp_in = (kind == 2);
      strobe_in    = 1'b1;
      @(negedge clk);
      strobe_in    = 1'b0;
      cmd_in       = rand_wide()[CW-1:0];
      no_resp_in   = 1'($urandom_range(0, 1));
      long_resp_in = 1'($urandom_range(0, 1));
      check_bit("load_latency", load_send, 1'b1);
      check_vec("cmd_to_pts", RW'(cmd_to_pts), RW'(cmd));
      check_bit("timeout_cleared", cmd_timeout, 1'b0);

      for (int a = 0; a < atts; a++) begin
         if (a > 0) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (load_send) begin
                  got = 1'b1;
                  break;
               end
            end
            check_bit("retry_load_seen", got, 1'b1);
         end
         repeat (tx_delay) @(negedge clk);
         check_bit("send_pad_enable", pad_enable, 1'b1);
         check_bit("send_pts_enable", en_pts, 1'b1);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         if (kind == 0) begin
            check_bit("noresp_strobe_latency", strobe_out, 1'b1);
         end else begin
            check_bit("wait_pad_stable", pad_stable, 1'b1);
            check_bit("wait_pad_released", pad_enable, 1'b0);
            check_bit("wait_stp_enable", en_stp, 1'b1);
            if (kind == 3) begin
               repeat (TO - 1) @(negedge clk);
               check_bit("no_early_timeout", strobe_out, 1'b0);
               if (a == atts - 1) begin
                  @(negedge clk);
                  check_bit("timeout_strobe_latency", strobe_out, 1'b1);
               end
            end else begin
               repeat (rx_delay) @(negedge clk);
               rx_done  = 1'b1;
               pad_resp = pad;
               @(negedge clk);
               rx_done  = 1'b0;
               pad_resp = rand_wide();
               check_bit("rx_strobe_latency", strobe_out, 1'b1);
            end
         end
      end

      repeat ($urandom_range(0, 3)) begin
         @(negedge clk);
         check_bit("strobe_held", strobe_out, 1'b1);
      end
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
      check_bit("ack_pulse", ack_out, 1'b1);
      check_bit("ack_strobe_low", strobe_out, 1'b0);
      check_bit("ack_wrapper_reset", reset_wrapper, 1'b1);
      @(negedge clk);
      check_bit("ack_single_pulse", ack_out, 1'b0);
      check_int("load_pulses", load_cnt - base, atts);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [RW-1:0] long_pad;
      int            kind;
      checks       = 0;
      errors       = 0;
      model_resp   = '0;
      rst          = 1'b1;
      strobe_in    = 1'b0;
      cmd_in       = '0;
      no_resp_in   = 1'b0;
      long_resp_in = 1'b0;
      tx_done      = 1'b0;
      rx_done      = 1'b0;
      pad_resp     = '0;
      ack_in       = 1'b0;
      idle_in      = 1'b0;

      repeat (2) @(negedge clk);
      check_bit("reset_strobe", strobe_out, 1'b0);
      check_bit("reset_wrapper", reset_wrapper, 1'b0);
      check_vec("reset_response", response, '0);
      rst = 1'b0;
      @(negedge clk);
      check_bit("post_reset_wrapper_pulse", reset_wrapper, 1'b1);
      @(negedge clk);
      check_bit("post_reset_wrapper_low", reset_wrapper, 1'b0);

      do_txn(0, 48'h400000000095, '0, 48, 0);
      do_txn(1, 48'h48000001AA87, {{(RW - CW){1'b1}}, 48'h08000001AA13}, 48, 5);
      long_pad = 136'h3F_0123456789ABCDEF_0123456789ABCDEF;
      do_txn(2, 48'h420000000001, long_pad, 48, 10);
      do_txn(3, 48'h4D0000000001, '0, 48, 0);
      do_txn(1, 48'h48000001AA87, rand_wide(), 4, TO - 1);
      do_txn(2, 48'h420000000001, rand_wide(), 3, TO - 1);

      // Abort mid-SEND.
      cmd_in    = 48'h48000001AA87;
      strobe_in = 1'b1;
      @(negedge clk);
      strobe_in = 1'b0;
      @(negedge clk);
      idle_in = 1'b1;
      @(negedge clk);
      idle_in = 1'b0;
      check_bit("abort_pad_enable", pad_enable, 1'b0);
      check_bit("abort_pts_enable", en_pts, 1'b0);
      check_bit("abort_wrapper_reset", reset_wrapper, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check_bit("abort_no_strobe", strobe_out, 1'b0);
      end
      check_bit("abort_wrapper_single", reset_wrapper, 1'b0);

      for (int n = 0; n < 16; n++) begin
         kind = $urandom_range(0, 3);
         do_txn(kind, rand_wide()[CW-1:0], rand_wide(), $urandom_range(1, 8),
                $urandom_range(0, TO - 1));
      end

      // Asynchronous reset mid-WAIT.
      do_txn(2, 48'h420000000001, long_pad, 2, 1);
      cmd_in       = 48'h48000001AA87;
      no_resp_in   = 1'b0;
      long_resp_in = 1'b0;
      strobe_in    = 1'b1;
      @(negedge clk);
      strobe_in = 1'b0;
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (5) @(negedge clk);
      check_bit("pre_reset_in_wait", en_stp, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_bit("async_reset_stp", en_stp, 1'b0);
      check_bit("async_reset_pad_stable", pad_stable, 1'b0);
      check_vec("async_reset_response", response, '0);
      check_vec("async_reset_cmd", RW'(cmd_to_pts), '0);
      model_resp = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_bit("rereset_wrapper_pulse", reset_wrapper, 1'b1);
      do_txn(0, 48'h400000000095, '0, 6, 0);

      repeat (4) @(negedge clk);
      check_int("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
